// File: rtl/truth_table_scanner_if.sv
// Bus between the truth-table scanner and its consumer.
// The consumer owns start and the lab function response; the scanner owns the rest.
interface truth_table_scanner_if;
    logic        i_start;
    logic        i_f_in;
    logic [3:0]  o_abcd;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_table;
    logic [4:0]  o_ones;
    logic        o_pass;

    modport master (
        output i_start,
        output i_f_in,
        input  o_abcd,
        input  o_busy,
        input  o_done,
        input  o_table,
        input  o_ones,
        input  o_pass
    );

    modport slave (
        input  i_start,
        input  i_f_in,
        output o_abcd,
        output o_busy,
        output o_done,
        output o_table,
        output o_ones,
        output o_pass
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Sweeps {a,b,c,d} through 0..15, samples f_in after SETTLE cycles per vector,
// and reports the captured truth table, its ones count and a compare result.
module truth_table_scanner #(
    parameter int unsigned SETTLE   = 2,
    parameter logic [15:0] EXPECTED = 16'hF232
) (
    input logic                  clk,
    input logic                  rst_n,
    truth_table_scanner_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LP_LAST = 4'(SETTLE - 1);

    state_t      r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [3:0]  r_abcd;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_table;
    logic [4:0]  r_ones;
    logic        r_pass;

    logic        w_sample;
    logic [15:0] w_table_nxt;
    logic [4:0]  w_ones_nxt;

    assign w_sample   = (r_cnt == LP_LAST);
    assign w_ones_nxt = r_ones + {4'd0, bus.i_f_in};

    always_comb begin
        w_table_nxt        = r_table;
        w_table_nxt[r_idx] = bus.i_f_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= 4'd0;
            r_abcd  <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= 16'd0;
            r_ones  <= 5'd0;
            r_pass  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_state <= ST_DRIVE;
                        r_idx   <= 4'd0;
                        r_cnt   <= 4'd0;
                        r_abcd  <= 4'd0;
                        r_busy  <= 1'b1;
                        r_table <= 16'd0;
                        r_ones  <= 5'd0;
                        r_pass  <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (w_sample) begin
                        r_table <= w_table_nxt;
                        r_ones  <= w_ones_nxt;
                        r_cnt   <= 4'd0;
                        // Last vector finishes here; abcd stays at 15 through DONE.
                        if (r_idx == 4'hF) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= (w_table_nxt == EXPECTED);
                        end else begin
                            r_idx  <= r_idx + 4'd1;
                            r_abcd <= r_idx + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_abcd  <= 4'd0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_abcd  = r_abcd;
    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.o_table = r_table;
    assign bus.o_ones  = r_ones;
    assign bus.o_pass  = r_pass;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: three instances with SETTLE = 1, 2, 4,
// a scoreboard of expected scan results, and per-cycle vector timing checks.
module tb_truth_table_scanner;

    typedef struct packed {
        logic [15:0] tbl;
        logic [4:0]  ones;
        logic        pass;
    } exp_t;

    typedef struct packed {
        logic [3:0]  abcd;
        logic        busy;
        logic        done;
        logic [15:0] tbl;
        logic [4:0]  ones;
        logic        pass;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] r_st;
    logic [1:0] fmode;

    int   checks;
    int   errors;
    exp_t sb[$];

    truth_table_scanner_if if1 ();
    truth_table_scanner_if if2 ();
    truth_table_scanner_if if4 ();

    truth_table_scanner #(.SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    truth_table_scanner #(.SETTLE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    truth_table_scanner #(.SETTLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // f4 = b&~c | a&b | ~c&d with a as the MSB
    function automatic logic f4(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (b & ~c) | (a & b) | (~c & d);
    endfunction

    assign if1.i_f_in  = (fmode == 2'd0) ? f4(if1.o_abcd) : (fmode == 2'd2);
    assign if2.i_f_in  = (fmode == 2'd0) ? f4(if2.o_abcd) : (fmode == 2'd2);
    assign if4.i_f_in  = (fmode == 2'd0) ? f4(if4.o_abcd) : (fmode == 2'd2);
    assign if1.i_start = r_st[0];
    assign if2.i_start = r_st[1];
    assign if4.i_start = r_st[2];

    function automatic int settle_of(input int sel);
        case (sel)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic obs_t obs(input int sel);
        obs_t o;
        case (sel)
            0: o = {if1.o_abcd, if1.o_busy, if1.o_done, if1.o_table, if1.o_ones, if1.o_pass};
            1: o = {if2.o_abcd, if2.o_busy, if2.o_done, if2.o_table, if2.o_ones, if2.o_pass};
            default: o = {if4.o_abcd, if4.o_busy, if4.o_done, if4.o_table, if4.o_ones, if4.o_pass};
        endcase
        return o;
    endfunction

    function automatic exp_t expect_of(input logic [1:0] mode);
        exp_t e;
        logic bit_v;
        e = '0;
        for (int k = 0; k < 16; k++) begin
            bit_v = (mode == 2'd0) ? f4(4'(k)) : (mode == 2'd2);
            e.tbl[k] = bit_v;
            e.ones = e.ones + {4'd0, bit_v};
        end
        e.pass = (e.tbl == 16'hF232);
        return e;
    endfunction

    task automatic scan(input int sel, input bit hold, input bit noise);
        int   s;
        int   n;
        exp_t e;
        exp_t got;
        obs_t o;
        s   = settle_of(sel);
        n   = 16 * s;
        got = expect_of(fmode);
        sb.push_back(got);
        r_st[sel] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) r_st[sel] = 1'b0;
        for (int j = 0; j <= n + 1; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            o = obs(sel);
            if (j < n) begin
                checks++;
                if (o.abcd !== 4'(j / s) || o.busy !== 1'b1 || o.done !== 1'b0 || o.pass !== 1'b0) begin
                    errors++;
                    $display("FAIL drive s=%0d cyc=%0d: abcd=%0d busy=%b done=%b pass=%b, want abcd=%0d busy=1 done=0 pass=0",
                             s, j, o.abcd, o.busy, o.done, o.pass, j / s);
                end
                if (j == 0) begin
                    checks++;
                    if (o.tbl !== 16'h0000 || o.ones !== 5'd0) begin
                        errors++;
                        $display("FAIL clear s=%0d: table=%h ones=%0d, want 0000 0", s, o.tbl, o.ones);
                    end
                end
            end else if (j == n) begin
                checks++;
                if (o.done !== 1'b1 || o.busy !== 1'b1 || o.abcd !== 4'hF) begin
                    errors++;
                    $display("FAIL done_timing s=%0d: done=%b busy=%b abcd=%0d, want 1 1 15", s, o.done, o.busy, o.abcd);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard s=%0d: empty queue at done", s);
                end else begin
                    e = sb.pop_front();
                    if (o.tbl !== e.tbl || o.ones !== e.ones || o.pass !== e.pass) begin
                        errors++;
                        $display("FAIL result s=%0d: table=%h ones=%0d pass=%b, want %h %0d %b",
                                 s, o.tbl, o.ones, o.pass, e.tbl, e.ones, e.pass);
                    end
                end
            end else begin
                checks++;
                if (o.busy !== 1'b0 || o.done !== 1'b0 || o.abcd !== 4'd0) begin
                    errors++;
                    $display("FAIL idle s=%0d: busy=%b done=%b abcd=%0d, want 0 0 0", s, o.busy, o.done, o.abcd);
                end
                checks++;
                if (o.tbl !== got.tbl || o.ones !== got.ones || o.pass !== got.pass) begin
                    errors++;
                    $display("FAIL hold s=%0d: table=%h ones=%0d pass=%b, want %h %0d %b",
                             s, o.tbl, o.ones, o.pass, got.tbl, got.ones, got.pass);
                end
            end
            if (noise && !hold)
                r_st[sel] = (j <= n) && ((j % 5 == 3) || (j >= n - 1));
        end
        if (!hold) r_st[sel] = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0;
        r_st  = 3'b000;
        fmode = 2'd0;
        #1;
        for (int i = 0; i < 3; i++) begin
            o = obs(i);
            checks++;
            if (o !== '0) begin
                errors++;
                $display("FAIL reset_asserted inst=%0d: outputs=%h, want 0", i, o);
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                o = obs(i);
                checks++;
                if (o !== '0) begin
                    errors++;
                    $display("FAIL reset_idle inst=%0d cyc=%0d: outputs=%h, want 0", i, c, o);
                end
            end
        end
    endtask

    task automatic test_golden();
        obs_t o;
        fmode = 2'd0;
        scan(1, 1'b0, 1'b0);
        o = obs(1);
        checks++;
        if (o.tbl !== 16'hF232 || o.ones !== 5'd8 || o.pass !== 1'b1) begin
            errors++;
            $display("FAIL golden: table=%h ones=%0d pass=%b, want f232 8 1", o.tbl, o.ones, o.pass);
        end
    endtask

    task automatic test_stuck();
        obs_t o;
        fmode = 2'd1;
        scan(1, 1'b0, 1'b0);
        o = obs(1);
        checks++;
        if (o.tbl !== 16'h0000 || o.ones !== 5'd0 || o.pass !== 1'b0) begin
            errors++;
            $display("FAIL stuck0: table=%h ones=%0d pass=%b, want 0000 0 0", o.tbl, o.ones, o.pass);
        end
        fmode = 2'd2;
        scan(1, 1'b0, 1'b0);
        o = obs(1);
        checks++;
        if (o.tbl !== 16'hFFFF || o.ones !== 5'd16 || o.pass !== 1'b0) begin
            errors++;
            $display("FAIL stuck1: table=%h ones=%0d pass=%b, want ffff 16 0", o.tbl, o.ones, o.pass);
        end
        fmode = 2'd0;
    endtask

    task automatic test_settle_sweep();
        fmode = 2'd0;
        scan(0, 1'b0, 1'b0);
        scan(2, 1'b0, 1'b0);
        fmode = 2'd1;
        scan(2, 1'b0, 1'b0);
        fmode = 2'd0;
    endtask

    task automatic test_midscan_reset();
        obs_t o;
        int   waited;
        fmode = 2'd2;
        r_st[1] = 1'b1;
        @(posedge clk);
        #1;
        r_st[1] = 1'b0;
        waited = 0;
        while (obs(1).abcd !== 4'd7 && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (waited >= 100) begin
            errors++;
            $display("FAIL midscan_wait: abcd=%0d never reached 7", obs(1).abcd);
        end
        rst_n = 1'b0;
        #1;
        o = obs(1);
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL midscan_reset: outputs=%h, want 0", o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fmode = 2'd0;
        scan(1, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        obs_t o;
        fmode = 2'd0;
        scan(1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        o = obs(1);
        checks++;
        if (o.busy !== 1'b0 || o.pass !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: busy=%b pass=%b, want 0 1", o.busy, o.pass);
        end
    endtask

    task automatic test_back_to_back();
        fmode = 2'd1;
        scan(0, 1'b1, 1'b0);
        fmode = 2'd0;
        scan(0, 1'b1, 1'b0);
        scan(0, 1'b1, 1'b0);
        r_st[0] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (obs(0).busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: busy=%b, want 0", obs(0).busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_golden();
        test_stuck();
        test_settle_sweep();
        test_midscan_reset();
        test_start_ignored();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential stimulus-and-capture engine for 4-input combinational lab functions. On `start` it drives `{a,b,c,d}` through 0..15 into a function under test. It samples the single-bit response after a programmable settle time and assembles the 16-bit truth table. It then reports the number of ones and a pass/fail compare against an expected table. It sits beside a combinational lab block and replaces the free-running sweep-and-monitor testbench with a synthesizable, self-checking scan.

## Interface
Parameters:
- `SETTLE`, default 2: cycles each vector is held before its response is sampled; legal range 1..15.
- `EXPECTED`, default 16'hF232: expected truth table, bit k = f({a,b,c,d}=k). The default is f4 = b&~c | a&b | ~c&d.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  scan request; sampled only in IDLE.
- `f_in`  in  1  response of the function under test. It is combinational from `abcd` and sampled synchronously with no synchronizer.
- `abcd`  out  4  current vector {a,b,c,d}; a is the MSB.
- `busy`  out  1  high in DRIVE and DONE.
- `done`  out  1  one-cycle pulse when results become valid.
- `table`  out  16  captured truth table; bit k holds the response to vector k.
- `ones`  out  5  count of 1 responses, range 0..16.
- `pass`  out  1  `table == EXPECTED`; valid from `done` onward.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE: `abcd` = 0 and `busy` = 0. If `start` = 1 at an edge:
  - Go to DRIVE.
  - Set index = 0 and settle counter = 0.
  - Clear `table`, `ones` and `pass`.
- DRIVE:
  - `abcd` = index.
  - The settle counter increments each cycle.
  - On the edge ending the SETTLE-th cycle of a vector:
    - Write `f_in` into `table[index]`.
    - Increment `ones` if `f_in` = 1.
    - Reset the settle counter.
    - If index = 15, go to DONE; otherwise increment index.
- DONE: one cycle only.
  - `done` = 1 and `pass` = (`table` == EXPECTED).
  - Return to IDLE unconditionally.
  - `abcd` holds 15 during DONE and returns to 0 in IDLE.
- `start` is ignored in DRIVE and DONE; there is no queuing.
- `table`, `ones` and `pass` hold their values in IDLE until the next accepted `start`.
- `ones` is 5 bits wide, so the count of 16 does not wrap.
- Index is 4 bits. No wrap occurs because the 15→DONE transition takes priority over increment.

## Timing
- Reset (`rst_n` = 0, effective immediately, no clock needed):
  - State goes to IDLE.
  - `abcd`, `busy`, `done`, `table`, `ones` and `pass` all go to 0.
- Reset mid-scan aborts the scan. Partial results are discarded.
- Let E0 be the edge that accepts `start`:
  - `busy` rises after E0 and `abcd` = 0 is driven after E0.
  - Vector k is driven from edge E0+k·SETTLE and sampled at edge E0+(k+1)·SETTLE.
  - Each vector is held for exactly SETTLE cycles.
  - `done` = 1 during the cycle after edge E0+16·SETTLE.
  - Latency from E0 to `done` is 16·SETTLE+1 cycles.
  - `busy` falls at the edge ending DONE.
- If `start` is held high continuously, the next scan is accepted at the first IDLE edge. Scans therefore run back-to-back with exactly one IDLE cycle between them.
- `pass` and `ones` are never observable in an intermediate state as final results. Consumers qualify them with `done` or read them in IDLE.

## Test plan
- Reset check: hold `rst_n` = 0, then release with `start` = 0 for 10 cycles. Required: `abcd` = 0, `busy` = 0, `done` = 0, `table` = 0, `ones` = 0, `pass` = 0 throughout.
- Golden function, SETTLE = 2: drive `f_in` from a model of f4 = b&~c | a&b | ~c&d and pulse `start`. Required: `done` pulses exactly 33 cycles after E0, `table` = 16'hF232, `ones` = 8, `pass` = 1.
- Stuck responses:
  - `f_in` tied 0: required `table` = 16'h0000, `ones` = 0, `pass` = 0.
  - `f_in` tied 1: required `table` = 16'hFFFF, `ones` = 16, `pass` = 0.
- Parameter sweep: with SETTLE = 1 and SETTLE = 4, each `abcd` value 0..15 is held exactly SETTLE cycles. `done` latency is 17 and 65 cycles respectively. With the golden model, `pass` = 1 in both cases.
- Mid-scan reset: assert `rst_n` = 0 while `abcd` = 7. Required: all outputs are 0 before the next edge. A following `start` runs a full 0..15 scan with correct results.
- Start handling:
  - Pulsing `start` during DRIVE and during DONE has no effect.
  - Holding `start` high runs back-to-back scans with `busy` low for exactly one cycle between them.
  - `table` is cleared at each new acceptance.
